// File: rtl/softex_den_inv_arbiter.sv
// Round-robin share of one softex_den_inverter between N_REQ lanes.
// Issue IDs ride an in-order FIFO so results route back to their issuer.
module softex_den_inv_arbiter #(
  parameter int N_REQ        = 4,
  parameter int WIDTH        = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*WIDTH-1:0] req_den_i,
  output logic [N_REQ-1:0]       resp_valid_o,
  input  logic [N_REQ-1:0]       resp_ready_i,
  output logic [WIDTH-1:0]       resp_inv_o,
  output logic                   inv_valid_o,
  input  logic                   inv_ready_i,
  output logic [WIDTH-1:0]       inv_den_o,
  input  logic                   inv_valid_i,
  output logic                   inv_ready_o,
  input  logic [WIDTH-1:0]       inv_res_i,
  output logic                   inv_clear_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW  = $clog2(MAX_INFLIGHT + 1);

  logic [IDW-1:0] rr_q, rr_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [IDW-1:0] fifo_q [MAX_INFLIGHT];
  logic [IDW-1:0] fifo_d [MAX_INFLIGHT];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           err_q, err_d;

  logic           soft_rst;
  logic           full;
  logic           empty;
  logic           found;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] rr_grant;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] head;
  logic           head_ready;
  logic           push;
  logic           pop;
  int             idx;

  assign soft_rst    = rst_i | clear_i;
  assign inv_clear_o = soft_rst;
  assign full        = (count_q == CW'(MAX_INFLIGHT));
  assign empty       = (count_q == '0);
  assign busy_o      = ~empty;
  assign err_o       = err_q;
  assign head        = fifo_q[rd_ptr_q];

  // first valid requester at or after the rr pointer
  always_comb begin
    rr_grant = '0;
    found    = 1'b0;
    cand     = '0;
    idx      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx  = (int'(rr_q) + i) % N_REQ;
      cand = IDW'(idx);
      if (!found && req_valid_i[cand]) begin
        found    = 1'b1;
        rr_grant = cand;
      end
    end
  end

  assign grant       = lock_q ? lock_id_q : rr_grant;
  assign inv_valid_o = lock_q | (found & ~full);
  assign push        = inv_valid_o & inv_ready_i;

  always_comb begin
    inv_den_o   = '0;
    req_ready_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == IDW'(i)) begin
        inv_den_o      = req_den_i[i*WIDTH +: WIDTH];
        req_ready_o[i] = push;
      end
    end
  end

  always_comb begin
    head_ready   = 1'b0;
    resp_valid_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (head == IDW'(i)) begin
        head_ready      = resp_ready_i[i];
        resp_valid_o[i] = inv_valid_i & ~empty;
      end
    end
  end

  assign resp_inv_o  = inv_res_i;
  assign inv_ready_o = empty ? 1'b1 : head_ready;
  assign pop         = inv_valid_i & ~empty & head_ready;

  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    if (push) begin
      fifo_d[wr_ptr_d] = grant;
      wr_ptr_d = (wr_ptr_q == PW'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_q + 1'b1;
      rr_d     = (grant == IDW'(N_REQ - 1)) ? '0 : grant + 1'b1;
      lock_d   = 1'b0;
    end else if (inv_valid_o) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (inv_valid_i && empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      fifo_q    <= fifo_d;
    end
  end

endmodule

// File: tb/tb_softex_den_inv_arbiter.sv
// Directed bench for softex_den_inv_arbiter; the bench plays the inverter.
// Inputs change at negedge, outputs are checked 1 time unit later.
module tb_softex_den_inv_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         clear_i;
  logic [3:0]   req_valid_i;
  logic [3:0]   req_ready_o;
  logic [127:0] req_den_i;
  logic [3:0]   resp_valid_o;
  logic [3:0]   resp_ready_i;
  logic [31:0]  resp_inv_o;
  logic         inv_valid_o;
  logic         inv_ready_i;
  logic [31:0]  inv_den_o;
  logic         inv_valid_i;
  logic         inv_ready_o;
  logic [31:0]  inv_res_i;
  logic         inv_clear_o;
  logic         busy_o;
  logic         err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  softex_den_inv_arbiter #(
    .N_REQ(4), .WIDTH(32), .MAX_INFLIGHT(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_den_i(req_den_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_inv_o(resp_inv_o),
    .inv_valid_o(inv_valid_o), .inv_ready_i(inv_ready_i),
    .inv_den_o(inv_den_o),
    .inv_valid_i(inv_valid_i), .inv_ready_o(inv_ready_o),
    .inv_res_i(inv_res_i),
    .inv_clear_o(inv_clear_o), .busy_o(busy_o), .err_o(err_o)
  );

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; clear_i = 1'b0;
    req_valid_i = '0; resp_ready_i = '1; inv_ready_i = 1'b1;
    inv_valid_i = 1'b0; inv_res_i = '0;
    for (int i = 0; i < 4; i++) req_den_i[i*32 +: 32] = 32'h100 + i;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if ({req_ready_o, resp_valid_o, inv_valid_o, busy_o, err_o} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_outs got %b want 0",
               {req_ready_o, resp_valid_o, inv_valid_o, busy_o, err_o});
    end
    n_tests++;
    if (inv_ready_o !== 1'b1 || inv_clear_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_inv got rdy=%b clr=%b want 1 0", inv_ready_o, inv_clear_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid_i = 4'b0100;
    req_den_i[64 +: 32] = 32'h4000_0000;
    #1;
    n_tests++;
    if (req_ready_o !== 4'b0100 || inv_den_o !== 32'h4000_0000 || inv_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_issue got rdy=%b den=%h want 0100 40000000", req_ready_o, inv_den_o);
    end
    @(negedge clk_i);
    req_valid_i = '0;
    inv_valid_i = 1'b1; inv_res_i = 32'h3F00_0000;
    #1;
    n_tests++;
    if (resp_valid_o !== 4'b0100 || resp_inv_o !== 32'h3F00_0000 || inv_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_resp got v=%b d=%h want 0100 3f000000", resp_valid_o, resp_inv_o);
    end
    @(negedge clk_i);
    inv_valid_i = 1'b0;
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done got busy=%b err=%b want 0 0", busy_o, err_o);
    end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      req_valid_i = (k < 8) ? 4'hF : 4'h0;
      inv_valid_i = (k >= 2);
      inv_res_i   = (k >= 2) ? 32'h100 + ((k - 2) % 4) : 32'h0;
      #1;
      if (k < 8) begin
        n_tests++;
        if (req_ready_o !== 4'(1 << (k % 4)) || inv_den_o !== 32'h100 + (k % 4)) begin
          n_fail++;
          $display("FAIL rr_grant k=%0d got %b den=%h want %b", k, req_ready_o,
                   inv_den_o, 4'(1 << (k % 4)));
        end
      end
      if (k >= 2) begin
        n_tests++;
        if (resp_valid_o !== 4'(1 << ((k - 2) % 4)) || inv_ready_o !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_resp k=%0d got %b want %b", k, resp_valid_o,
                   4'(1 << ((k - 2) % 4)));
        end
      end
    end
    @(negedge clk_i);
    inv_valid_i = 1'b0;
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drain got busy=%b err=%b want 0 0", busy_o, err_o);
    end
  endtask

  task automatic test_lock();
    do_reset();
    inv_ready_i = 1'b0;
    req_valid_i = 4'b0010;
    req_den_i[0 +: 32]  = 32'hA0;
    req_den_i[32 +: 32] = 32'hA1;
    #1;
    n_tests++;
    if (inv_valid_o !== 1'b1 || inv_den_o !== 32'hA1 || req_ready_o !== 4'b0) begin
      n_fail++;
      $display("FAIL lock_stall got v=%b den=%h rdy=%b want 1 a1 0000",
               inv_valid_o, inv_den_o, req_ready_o);
    end
    @(negedge clk_i);
    req_valid_i = 4'b0011;
    #1;
    n_tests++;
    if (inv_den_o !== 32'hA1 || req_ready_o !== 4'b0) begin
      n_fail++;
      $display("FAIL lock_hold got den=%h rdy=%b want a1 0000", inv_den_o, req_ready_o);
    end
    @(negedge clk_i);
    inv_ready_i = 1'b1;
    #1;
    n_tests++;
    if (req_ready_o !== 4'b0010 || inv_den_o !== 32'hA1) begin
      n_fail++;
      $display("FAIL lock_accept got rdy=%b den=%h want 0010 a1", req_ready_o, inv_den_o);
    end
    @(negedge clk_i);
    req_valid_i = 4'b0001;
    #1;
    n_tests++;
    if (req_ready_o !== 4'b0001 || inv_den_o !== 32'hA0) begin
      n_fail++;
      $display("FAIL lock_next got rdy=%b den=%h want 0001 a0", req_ready_o, inv_den_o);
    end
  endtask

  task automatic test_full();
    do_reset();
    resp_ready_i = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      req_valid_i = 4'hF;
      #1;
      n_tests++;
      if (inv_valid_o !== 1'b1 || req_ready_o !== 4'(1 << k)) begin
        n_fail++;
        $display("FAIL full_issue k=%0d got v=%b rdy=%b want 1 %b", k, inv_valid_o,
                 req_ready_o, 4'(1 << k));
      end
    end
    @(negedge clk_i);
    inv_valid_i = 1'b1; inv_res_i = 32'h55;
    #1;
    n_tests++;
    if (inv_valid_o !== 1'b0 || req_ready_o !== 4'b0 || busy_o !== 1'b1 ||
        resp_valid_o !== 4'b0001 || inv_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_block got v=%b rdy=%b rv=%b irdy=%b want 0 0000 0001 0",
               inv_valid_o, req_ready_o, resp_valid_o, inv_ready_o);
    end
    @(negedge clk_i);
    resp_ready_i = '1;
    #1;
    n_tests++;
    if (inv_valid_o !== 1'b0 || resp_valid_o !== 4'b0001 || inv_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop got v=%b rv=%b irdy=%b want 0 0001 1",
               inv_valid_o, resp_valid_o, inv_ready_o);
    end
    @(negedge clk_i);
    inv_valid_i = 1'b0;
    #1;
    n_tests++;
    if (inv_valid_o !== 1'b1 || req_ready_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL full_resume got v=%b rdy=%b want 1 0001", inv_valid_o, req_ready_o);
    end
  endtask

  task automatic test_error();
    do_reset();
    inv_valid_i = 1'b1; inv_res_i = 32'hDEAD;
    #1;
    n_tests++;
    if (inv_ready_o !== 1'b1 || resp_valid_o !== 4'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_inject got irdy=%b rv=%b err=%b want 1 0000 0",
               inv_ready_o, resp_valid_o, err_o);
    end
    @(negedge clk_i);
    inv_valid_i = 1'b0;
    #1;
    n_tests++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set got %b want 1", err_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    n_tests++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_sticky got err=%b busy=%b want 1 0", err_o, busy_o);
    end
  endtask

  task automatic test_clear();
    do_reset();
    inv_valid_i = 1'b1;
    @(negedge clk_i);
    inv_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid_i = 4'hF;
      @(negedge clk_i);
    end
    req_valid_i = 4'h0;
    #1;
    n_tests++;
    if (busy_o !== 1'b1 || err_o !== 1'b1 || inv_clear_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_pre got busy=%b err=%b clr=%b want 1 1 0", busy_o, err_o, inv_clear_o);
    end
    clear_i = 1'b1;
    #1;
    n_tests++;
    if (inv_clear_o !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_pulse got %b want 1", inv_clear_o);
    end
    @(negedge clk_i);
    clear_i = 1'b0;
    req_valid_i = 4'hF;
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || err_o !== 1'b0 || req_ready_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL clr_post got busy=%b err=%b rdy=%b want 0 0 0001",
               busy_o, err_o, req_ready_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0;
    req_valid_i = '0; req_den_i = '0; resp_ready_i = '0;
    inv_ready_i = 1'b0; inv_valid_i = 1'b0; inv_res_i = '0;
    test_reset();
    test_single();
    test_rr_fairness();
    test_lock();
    test_full();
    test_error();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
